regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter that drives the single write port (`write_reg`, `write_data`, `RegWrite`) of the MIPS `Registers` block.

- Merges two result producers:
  - the single-cycle ALU path, which has no backpressure and always wins;
  - the long-latency path (mult/div/load), which has a valid/ready handshake and is buffered in an in-order queue.
- Kills stale queued results when a newer ALU write targets the same register.
- Exports a per-register pending mask to the hazard unit.

## Interface
Parameters:
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register index width (32 registers)
- `LQ_DEPTH`, 4, long-path queue depth; power of two, ≥2

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU result present this cycle
- `alu_reg`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `lng_valid`  in  1  long-path result offered
- `lng_ready`  out  1  queue can accept; transfer when `lng_valid && lng_ready` at a clock edge
- `lng_reg`  in  ADDR_W  long-path destination register
- `lng_data`  in  DATA_W  long-path result
- `write_reg`  out  ADDR_W  to `Registers.write_reg`
- `write_data`  out  DATA_W  to `Registers.write_data`
- `RegWrite`  out  1  to `Registers.RegWrite`
- `busy_mask`  out  2**ADDR_W  bit r = live queued write pending for register r
- `lq_count`  out  clog2(LQ_DEPTH)+1  queue occupancy, including dead entries

## Operation
- Queue entries are {live, reg, data}. A push writes live=1 at the tail. A pop removes the head.
- Per-cycle issue decision, evaluated on the current inputs and queue state:
  1. If `alu_valid` and `alu_reg` != 0: issue the ALU write. The queue does not pop.
  2. Otherwise, if the queue is non-empty: pop the head. If the head is live and its reg != 0, issue it. If the head is dead, pop it silently with no write.
  3. Otherwise: no write.
- ALU writes to register 0 are dropped. They do not block the queue from issuing that cycle.
- Long-path pushes to register 0 are accepted but dropped; they do not occupy the queue.
- Kill rule: an issued ALU write to r clears `live` on every queued entry with reg == r. An entry pushed in the same cycle is treated as younger and is not killed.
- `lng_ready` = !full && !reset.
  - There is no push-while-full even if a pop occurs that cycle.
  - There is no bypass: a push into an empty queue issues at the earliest one cycle later.
- `busy_mask` is combinational: the OR over live entries of a one-hot of reg. Bit 0 is always 0.
- Overflow is impossible by construction. A transfer attempted while `lng_ready` = 0 is ignored, and the producer holds its data.

## Timing
- Write-port outputs are registered. A decision in cycle k drives `RegWrite`/`write_reg`/`write_data` during cycle k+1, and `Registers` commits at the end of cycle k+1.
- ALU latency: 1 cycle to the port.
- Long-path latency: at least 2 cycles from the accepting edge (enqueue, then pop), plus any cycles spent losing to the ALU.
- `busy_mask` and `lq_count` update on the edge of the push, pop or kill.
- Reset values, on asynchronous assertion (`rst` = 0):
  - `RegWrite` 0, `write_reg` 0, `write_data` 0;
  - queue empty, pointers 0, all live bits 0;
  - `lq_count` 0, `busy_mask` 0, `lng_ready` 0.
  - Reset mid-operation discards all queued results; no partial write is emitted.
- Deassertion is sampled at the next edge; `lng_ready` rises in the cycle after `rst` goes high.
- Pointer wrap: mod LQ_DEPTH. Full/empty are distinguished by an extra pointer MSB.

## Structure
- The shared MIPS definitions package/header holds `DATA_W`, `ADDR_W` and the register-0 constant. It is shared with `Registers` and the hazard unit.
- One sub-module: `wb_fifo`, a parameterised circular queue.
  - Inputs: push, pop, kill_en, kill_reg.
  - Outputs: head entry, full, empty, count, per-entry live/reg vectors for the mask.
- Top level holds the issue mux, the output registers, and the `busy_mask` reduction.

## Test plan
- Reset then idle: `rst`=0 → all outputs 0. Release → `lng_ready`=1 next cycle, `RegWrite`=0.
- ALU only: `alu_valid`=1, reg 10, data 9 → next cycle `RegWrite`=1, `write_reg`=10, `write_data`=9. Reading reg 10 after the following edge returns 9.
- Long only: push reg 4, data 18 with no ALU traffic → `busy_mask[4]`=1 for 1 cycle; the port shows reg 4 / 18 two cycles after acceptance; then `busy_mask`=0.
- Contention and backpressure:
  - Fill the queue with 4 pushes (regs 1–4) while the ALU writes every cycle → `lng_ready`=0, `lq_count`=4.
  - Drop the ALU → writes for regs 1, 2, 3, 4 in order on consecutive cycles.
- Kill: queue reg 8, data 36; then ALU writes reg 8, data 5 → port shows 8/5. `busy_mask[8]` clears. The queued entry pops with `RegWrite`=0, and register 8 stays 5.
- Register 0 and mid-run reset:
  - ALU and long writes to reg 0 → never `RegWrite`=1.
  - Assert `rst` with 3 entries queued → queue empty, no further writes after release.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
//   Shared MIPS definitions used by the register file, the hazard unit and the
//   write-back arbiter. It holds the data and index widths, the register-0
//   constant, and the issue-source encoding used by the arbiter.
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

   localparam int MIPS_DATA_W = 32;
   localparam int MIPS_ADDR_W = 5;

   // Register 0 is hard-wired to zero, so writes that target it are discarded.
   localparam logic [MIPS_ADDR_W-1:0] REG_ZERO = '0;

   // Source of this cycle's write-port decision.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,  // nothing issued
      SRC_ALU  = 2'd1,  // ALU result issued; the queue holds
      SRC_LNG  = 2'd2,  // live queue head issued and popped
      SRC_DEAD = 2'd3   // killed queue head popped with no write
   } issue_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
//   In-order circular queue of long-path results. Each entry is {live, reg,
//   data}. A kill clears live on every stored entry whose reg matches
//   kill_reg. An entry pushed in the same cycle is younger than the kill and
//   stays live.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   push, push_reg/data write a live entry at the tail (ignored when full)
//   pop                 remove the head entry (ignored when empty)
//   kill_en, kill_reg   clear live on stored entries with matching reg
//   head_live/reg/data  current head entry
//   full, empty, count  occupancy, dead entries included
//   live_vec, reg_vec   per-slot live bits and flattened reg fields
// -----------------------------------------------------------------------------
module wb_fifo #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [ADDR_W-1:0]         push_reg,
   input  logic [DATA_W-1:0]         push_data,
   input  logic                      pop,
   input  logic                      kill_en,
   input  logic [ADDR_W-1:0]         kill_reg,
   output logic                      head_live,
   output logic [ADDR_W-1:0]         head_reg,
   output logic [DATA_W-1:0]         head_data,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count,
   output logic [DEPTH-1:0]          live_vec,
   output logic [DEPTH*ADDR_W-1:0]   reg_vec
);

   localparam int PTR_W = $clog2(DEPTH);

   // Pointers carry one extra MSB so that full and empty can be told apart
   // when the slot indices are equal.
   logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0]    live_q, live_d;
   logic [ADDR_W-1:0]   reg_q  [DEPTH];
   logic [ADDR_W-1:0]   reg_d  [DEPTH];
   logic [DATA_W-1:0]   data_q [DEPTH];
   logic [DATA_W-1:0]   data_d [DEPTH];

   logic [PTR_W-1:0]    wr_idx;
   logic [PTR_W-1:0]    rd_idx;

   assign wr_idx = wr_ptr_q[PTR_W-1:0];
   assign rd_idx = rd_ptr_q[PTR_W-1:0];

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_idx == rd_idx);
   assign count = wr_ptr_q - rd_ptr_q;

   assign head_live = live_q[rd_idx];
   assign head_reg  = reg_q[rd_idx];
   assign head_data = data_q[rd_idx];

   assign live_vec = live_q;

   always_comb begin
      reg_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         reg_vec[i*ADDR_W +: ADDR_W] = reg_q[i];
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path leaves
      // a value unassigned and no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      live_d   = live_q;
      reg_d    = reg_q;
      data_d   = data_q;

      // The kill is applied first so that the tail push below overrides it.
      // This keeps a same-cycle push alive.
      if (kill_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (reg_q[i] == kill_reg)) begin
               live_d[i] = 1'b0;
            end
         end
      end

      if (pop && !empty) begin
         live_d[rd_idx] = 1'b0;
         rd_ptr_d       = rd_ptr_q + 1'b1;
      end

      if (push && !full) begin
         live_d[wr_idx] = 1'b1;
         reg_d[wr_idx]  = push_reg;
         data_d[wr_idx] = push_data;
         wr_ptr_d       = wr_ptr_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignment so that every flop
   // samples the values from before the edge, regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         live_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         live_q   <= live_d;
      end
   end

   // NOTE: the payload arrays are not reset. An entry is only read while its
   // slot is occupied, and occupancy and liveness come from the reset pointers
   // and live bits.
   always_ff @(posedge clk) begin
      reg_q  <= reg_d;
      data_q <= data_d;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Drives the single write port of the MIPS register file. The port has two
//   sources:
//   - the single-cycle ALU path, which has no backpressure and always wins;
//   - the long-latency path (mult/div/load), which uses a valid/ready
//     handshake into an in-order queue.
//   An issued ALU write kills older queued results for the same register.
//   A per-register pending mask goes to the hazard unit.
//
// Ports
//   clk, rst                        clock, asynchronous active-low reset
//   alu_valid/reg/data              ALU result for this cycle
//   lng_valid/ready/reg/data        long-path handshake into the queue
//   write_reg/write_data/RegWrite   registered write port to Registers
//   busy_mask                       bit r set when a live queued write to r
//                                   is pending
//   lq_count                        queue occupancy, dead entries included
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int DATA_W   = MIPS_DATA_W,
   parameter int ADDR_W   = MIPS_ADDR_W,
   parameter int LQ_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alu_valid,
   input  logic [ADDR_W-1:0]          alu_reg,
   input  logic [DATA_W-1:0]          alu_data,
   input  logic                       lng_valid,
   output logic                       lng_ready,
   input  logic [ADDR_W-1:0]          lng_reg,
   input  logic [DATA_W-1:0]          lng_data,
   output logic [ADDR_W-1:0]          write_reg,
   output logic [DATA_W-1:0]          write_data,
   output logic                       RegWrite,
   output logic [2**ADDR_W-1:0]       busy_mask,
   output logic [$clog2(LQ_DEPTH):0]  lq_count
);

   localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(REG_ZERO);

   logic                       rdy_q, rdy_d;
   logic                       reg_write_q, reg_write_d;
   logic [ADDR_W-1:0]          write_reg_q, write_reg_d;
   logic [DATA_W-1:0]          write_data_q, write_data_d;

   logic                       fifo_push;
   logic                       fifo_pop;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       head_live;
   logic [ADDR_W-1:0]          head_reg;
   logic [DATA_W-1:0]          head_data;
   logic [LQ_DEPTH-1:0]        live_vec;
   logic [LQ_DEPTH*ADDR_W-1:0] reg_vec;
   logic                       alu_issue;
   issue_src_e                 issue_src;

   // rdy_q stays low while reset is held. It rises on the first edge after
   // release, so the queue opens one cycle after rst goes high.
   assign rdy_d     = 1'b1;
   assign lng_ready = rdy_q && !fifo_full;

   // A handshake to register 0 completes but stores nothing.
   assign fifo_push = lng_valid && lng_ready && (lng_reg != ZERO_REG);

   always_comb begin
      issue_src = SRC_NONE;
      if (alu_valid && (alu_reg != ZERO_REG)) begin
         issue_src = SRC_ALU;
      end else if (!fifo_empty) begin
         issue_src = (head_live && (head_reg != ZERO_REG)) ? SRC_LNG : SRC_DEAD;
      end
   end

   assign alu_issue = (issue_src == SRC_ALU);
   assign fifo_pop  = (issue_src == SRC_LNG) || (issue_src == SRC_DEAD);

   wb_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (LQ_DEPTH)
   ) u_wb_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_reg  (lng_reg),
      .push_data (lng_data),
      .pop       (fifo_pop),
      .kill_en   (alu_issue),
      .kill_reg  (alu_reg),
      .head_live (head_live),
      .head_reg  (head_reg),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (lq_count),
      .live_vec  (live_vec),
      .reg_vec   (reg_vec)
   );

   // The write port strobes RegWrite only. Address and data hold between
   // writes, so the register-file inputs do not toggle without reason.
   always_comb begin
      reg_write_d  = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      unique case (issue_src)
         SRC_ALU: begin
            reg_write_d  = 1'b1;
            write_reg_d  = alu_reg;
            write_data_d = alu_data;
         end
         SRC_LNG: begin
            reg_write_d  = 1'b1;
            write_reg_d  = head_reg;
            write_data_d = head_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdy_q        <= 1'b0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         rdy_q        <= rdy_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign RegWrite   = reg_write_q;
   assign write_reg  = write_reg_q;
   assign write_data = write_data_q;

   // A live bit is cleared on pop, so it can only be set in an occupied slot.
   // Bit 0 is forced low because register 0 never has a pending write.
   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         if (live_vec[i]) begin
            busy_mask[reg_vec[i*ADDR_W +: ADDR_W]] = 1'b1;
         end
      end
      busy_mask[0] = 1'b0;
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed bench for the write-back arbiter. Inputs change 1 ns after a
//   rising edge and outputs are sampled at that same point. A small register
//   file model commits the write port on every rising edge, so the bench can
//   check which value a register finally holds.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_reg;
   logic [31:0] alu_data;
   logic        lng_valid;
   logic        lng_ready;
   logic [4:0]  lng_reg;
   logic [31:0] lng_data;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        RegWrite;
   logic [31:0] busy_mask;
   logic [2:0]  lq_count;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [31:0] regs_m [32];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (RegWrite) regs_m[write_reg] <= write_data;
   end

   regfile_wb_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_reg    (alu_reg),
      .alu_data   (alu_data),
      .lng_valid  (lng_valid),
      .lng_ready  (lng_ready),
      .lng_reg    (lng_reg),
      .lng_data   (lng_data),
      .write_reg  (write_reg),
      .write_data (write_data),
      .RegWrite   (RegWrite),
      .busy_mask  (busy_mask),
      .lq_count   (lq_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
      lng_valid = 1'b0; lng_reg = '0; lng_data = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      #2;
      total_cnt++; if (RegWrite !== 1'b0) $display("FAIL rst_regwrite: got %0d want 0", RegWrite); else pass_cnt++;
      total_cnt++; if (write_reg !== 5'd0) $display("FAIL rst_write_reg: got %0d want 0", write_reg); else pass_cnt++;
      total_cnt++; if (write_data !== 32'd0) $display("FAIL rst_write_data: got %0d want 0", write_data); else pass_cnt++;
      total_cnt++; if (lq_count !== 3'd0) $display("FAIL rst_lq_count: got %0d want 0", lq_count); else pass_cnt++;
      total_cnt++; if (busy_mask !== 32'd0) $display("FAIL rst_busy_mask: got %h want 0", busy_mask); else pass_cnt++;
      total_cnt++; if (lng_ready !== 1'b0) $display("FAIL rst_lng_ready: got %0d want 0", lng_ready); else pass_cnt++;
      tick();
      tick();
      rst = 1'b1;
      total_cnt++; if (lng_ready !== 1'b0) $display("FAIL release_ready_early: got %0d want 0", lng_ready); else pass_cnt++;
      tick();
      total_cnt++; if (lng_ready !== 1'b1) $display("FAIL release_ready: got %0d want 1", lng_ready); else pass_cnt++;
      total_cnt++; if (RegWrite !== 1'b0) $display("FAIL release_regwrite: got %0d want 0", RegWrite); else pass_cnt++;
   endtask

   task automatic test_alu_only();
      alu_valid = 1'b1; alu_reg = 5'd10; alu_data = 32'd9;
      tick();
      alu_valid = 1'b0;
      total_cnt++; if (RegWrite !== 1'b1) $display("FAIL alu_regwrite: got %0d want 1", RegWrite); else pass_cnt++;
      total_cnt++; if (write_reg !== 5'd10) $display("FAIL alu_write_reg: got %0d want 10", write_reg); else pass_cnt++;
      total_cnt++; if (write_data !== 32'd9) $display("FAIL alu_write_data: got %0d want 9", write_data); else pass_cnt++;
      tick();
      total_cnt++; if (RegWrite !== 1'b0) $display("FAIL alu_idle_after: got %0d want 0", RegWrite); else pass_cnt++;
      total_cnt++; if (regs_m[10] !== 32'd9) $display("FAIL alu_reg10_commit: got %0d want 9", regs_m[10]); else pass_cnt++;
   endtask

   task automatic test_long_only();
      lng_valid = 1'b1; lng_reg = 5'd4; lng_data = 32'd18;
      tick();
      lng_valid = 1'b0;
      total_cnt++; if (busy_mask !== 32'h0000_0010) $display("FAIL long_busy_set: got %h want 00000010", busy_mask); else pass_cnt++;
      total_cnt++; if (lq_count !== 3'd1) $display("FAIL long_count1: got %0d want 1", lq_count); else pass_cnt++;
      total_cnt++; if (RegWrite !== 1'b0) $display("FAIL long_no_bypass: got %0d want 0", RegWrite); else pass_cnt++;
      tick();
      total_cnt++; if (RegWrite !== 1'b1) $display("FAIL long_regwrite: got %0d want 1", RegWrite); else pass_cnt++;
      total_cnt++; if (write_reg !== 5'd4) $display("FAIL long_write_reg: got %0d want 4", write_reg); else pass_cnt++;
      total_cnt++; if (write_data !== 32'd18) $display("FAIL long_write_data: got %0d want 18", write_data); else pass_cnt++;
      total_cnt++; if (busy_mask !== 32'd0) $display("FAIL long_busy_clear: got %h want 0", busy_mask); else pass_cnt++;
      total_cnt++; if (lq_count !== 3'd0) $display("FAIL long_count0: got %0d want 0", lq_count); else pass_cnt++;
      tick();
      total_cnt++; if (RegWrite !== 1'b0) $display("FAIL long_idle_after: got %0d want 0", RegWrite); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 4; i++) begin
         alu_valid = 1'b1; alu_reg = 5'(20 + i); alu_data = 32'(200 + i);
         lng_valid = 1'b1; lng_reg = 5'(i);      lng_data = 32'(100 + i);
         tick();
         total_cnt++; if (write_reg !== 5'(20 + i) || RegWrite !== 1'b1)
            $display("FAIL b2b_alu_wins_%0d: got we=%0d reg=%0d want we=1 reg=%0d", i, RegWrite, write_reg, 20 + i);
         else pass_cnt++;
      end
      total_cnt++; if (lq_count !== 3'd4) $display("FAIL b2b_full_count: got %0d want 4", lq_count); else pass_cnt++;
      total_cnt++; if (lng_ready !== 1'b0) $display("FAIL b2b_full_ready: got %0d want 0", lng_ready); else pass_cnt++;
      total_cnt++; if (busy_mask !== 32'h0000_001E) $display("FAIL b2b_full_busy: got %h want 0000001e", busy_mask); else pass_cnt++;
      // A push offered while full must be ignored.
      alu_reg = 5'd25; alu_data = 32'd205; lng_reg = 5'd5; lng_data = 32'd105;
      tick();
      total_cnt++; if (lq_count !== 3'd4) $display("FAIL b2b_push_while_full: got %0d want 4", lq_count); else pass_cnt++;
      idle_inputs();
      for (int i = 1; i <= 4; i++) begin
         tick();
         total_cnt++; if (RegWrite !== 1'b1 || write_reg !== 5'(i) || write_data !== 32'(100 + i))
            $display("FAIL b2b_drain_%0d: got we=%0d reg=%0d data=%0d want we=1 reg=%0d data=%0d",
                     i, RegWrite, write_reg, write_data, i, 100 + i);
         else pass_cnt++;
      end
      tick();
      total_cnt++; if (RegWrite !== 1'b0 || lq_count !== 3'd0)
         $display("FAIL b2b_drained: got we=%0d count=%0d want we=0 count=0", RegWrite, lq_count);
      else pass_cnt++;
   endtask

   task automatic test_kill();
      alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'd7;
      lng_valid = 1'b1; lng_reg = 5'd8; lng_data = 32'd36;
      tick();
      total_cnt++; if (busy_mask[8] !== 1'b1) $display("FAIL kill_busy_set: got %0d want 1", busy_mask[8]); else pass_cnt++;
      lng_valid = 1'b0;
      alu_reg = 5'd8; alu_data = 32'd5;
      tick();
      alu_valid = 1'b0;
      total_cnt++; if (RegWrite !== 1'b1 || write_reg !== 5'd8 || write_data !== 32'd5)
         $display("FAIL kill_alu_write: got we=%0d reg=%0d data=%0d want we=1 reg=8 data=5", RegWrite, write_reg, write_data);
      else pass_cnt++;
      total_cnt++; if (busy_mask[8] !== 1'b0) $display("FAIL kill_busy_clear: got %0d want 0", busy_mask[8]); else pass_cnt++;
      total_cnt++; if (lq_count !== 3'd1) $display("FAIL kill_dead_held: got %0d want 1", lq_count); else pass_cnt++;
      tick();
      total_cnt++; if (RegWrite !== 1'b0) $display("FAIL kill_dead_pop_write: got %0d want 0", RegWrite); else pass_cnt++;
      total_cnt++; if (lq_count !== 3'd0) $display("FAIL kill_dead_popped: got %0d want 0", lq_count); else pass_cnt++;
      tick();
      total_cnt++; if (regs_m[8] !== 32'd5) $display("FAIL kill_reg8_final: got %0d want 5", regs_m[8]); else pass_cnt++;

      // A push in the same cycle as the ALU write is younger and survives.
      alu_valid = 1'b1; alu_reg = 5'd12; alu_data = 32'd1;
      lng_valid = 1'b1; lng_reg = 5'd12; lng_data = 32'd2;
      tick();
      idle_inputs();
      total_cnt++; if (busy_mask[12] !== 1'b1) $display("FAIL kill_young_busy: got %0d want 1", busy_mask[12]); else pass_cnt++;
      tick();
      total_cnt++; if (RegWrite !== 1'b1 || write_reg !== 5'd12 || write_data !== 32'd2)
         $display("FAIL kill_young_write: got we=%0d reg=%0d data=%0d want we=1 reg=12 data=2", RegWrite, write_reg, write_data);
      else pass_cnt++;
      tick();
      total_cnt++; if (regs_m[12] !== 32'd2) $display("FAIL kill_young_final: got %0d want 2", regs_m[12]); else pass_cnt++;
   endtask

   task automatic test_reg_zero();
      alu_valid = 1'b1; alu_reg = 5'd15; alu_data = 32'd3;
      lng_valid = 1'b1; lng_reg = 5'd6;  lng_data = 32'd60;
      tick();
      alu_reg = 5'd0; alu_data = 32'd55;
      lng_reg = 5'd0; lng_data = 32'd66;
      tick();
      idle_inputs();
      // An ALU write to r0 must not block the queue.
      total_cnt++; if (RegWrite !== 1'b1 || write_reg !== 5'd6 || write_data !== 32'd60)
         $display("FAIL r0_queue_issues: got we=%0d reg=%0d data=%0d want we=1 reg=6 data=60", RegWrite, write_reg, write_data);
      else pass_cnt++;
      total_cnt++; if (lq_count !== 3'd0) $display("FAIL r0_push_dropped: got %0d want 0", lq_count); else pass_cnt++;
      alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'd77;
      lng_valid = 1'b1; lng_reg = 5'd0; lng_data = 32'd88;
      tick();
      idle_inputs();
      total_cnt++; if (RegWrite !== 1'b0) $display("FAIL r0_no_write: got %0d want 0", RegWrite); else pass_cnt++;
      total_cnt++; if (lq_count !== 3'd0 || busy_mask !== 32'd0)
         $display("FAIL r0_queue_empty: got count=%0d busy=%h want 0/0", lq_count, busy_mask);
      else pass_cnt++;
      tick();
      total_cnt++; if (RegWrite !== 1'b0) $display("FAIL r0_still_no_write: got %0d want 0", RegWrite); else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      for (int i = 1; i <= 3; i++) begin
         alu_valid = 1'b1; alu_reg = 5'd30; alu_data = 32'(300 + i);
         lng_valid = 1'b1; lng_reg = 5'(i); lng_data = 32'(400 + i);
         tick();
      end
      idle_inputs();
      total_cnt++; if (lq_count !== 3'd3) $display("FAIL mrst_count3: got %0d want 3", lq_count); else pass_cnt++;
      rst = 1'b0;
      #1;
      total_cnt++; if (lq_count !== 3'd0 || busy_mask !== 32'd0)
         $display("FAIL mrst_queue_cleared: got count=%0d busy=%h want 0/0", lq_count, busy_mask);
      else pass_cnt++;
      total_cnt++; if (RegWrite !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0)
         $display("FAIL mrst_port_cleared: got we=%0d reg=%0d data=%0d want 0/0/0", RegWrite, write_reg, write_data);
      else pass_cnt++;
      total_cnt++; if (lng_ready !== 1'b0) $display("FAIL mrst_ready: got %0d want 0", lng_ready); else pass_cnt++;
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total_cnt++; if (RegWrite !== 1'b0 || lq_count !== 3'd0)
            $display("FAIL mrst_after_release_%0d: got we=%0d count=%0d want 0/0", i, RegWrite, lq_count);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_alu_only();
      test_long_only();
      test_back_to_back();
      test_kill();
      test_reg_zero();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
